axi_lite_rd_arbiter: RTL and testbench
======================================

Name: axi_lite_rd_arbiter

Overview:
- Arbitrates one shared AXI-lite read port to memory between two requesters: IFU instruction fetch (master 0) and LSU data load (master 1).
- Sits between the IFU/LSU read channels and the single memory read slave.
- Only one read transaction is outstanding at a time. The AR and R channels of the selected master are routed through while all other masters are held off.

Parameters:
- ADDR_W, 32, width of ARADDR on all ports.
- DATA_W, 64, width of RDATA on all ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_arvalid  in  1  IFU address valid.
- if_araddr  in  ADDR_W  IFU address.
- if_arready  out  1  IFU address accepted.
- if_rvalid  out  1  IFU read data valid.
- if_rdata  out  DATA_W  IFU read data.
- if_rresp  out  2  IFU read response.
- if_rready  in  1  IFU ready for data.
- ls_arvalid, ls_araddr, ls_arready, ls_rvalid, ls_rdata, ls_rresp, ls_rready: same directions, widths and meanings for the LSU.
- m_arvalid  out  1  memory address valid.
- m_araddr  out  ADDR_W  memory address.
- m_arready  in  1  memory address accepted.
- m_rvalid  in  1  memory read data valid.
- m_rdata  in  DATA_W  memory read data.
- m_rresp  in  2  memory read response.
- m_rready  out  1  ready for memory data.
- busy  out  1  state is not IDLE.
- grant_id  out  1  0 = IFU owns the port, 1 = LSU owns the port; meaningful only when busy=1.

Behaviour:
- FSM states: IDLE, AR_IF, R_IF, AR_LS, R_LS. The state is registered.
- Reset values:
  - state = IDLE.
  - All outputs are 0: m_arvalid, m_rready, if_arready, ls_arready, if_rvalid, ls_rvalid, busy, grant_id.
  - m_araddr is 0 while IDLE.
- IDLE:
  - No valid is forwarded and no arready is asserted to either master.
  - If exactly one xx_arvalid=1, go to AR_IF or AR_LS on the next edge.
  - If both are asserted, fixed priority applies: LSU wins (see the optional feature).
- AR_x:
  - m_arvalid = 1 and m_araddr = granted master's araddr.
  - Granted master's arready = m_arready.
  - On m_arvalid & m_arready, go to R_x.
  - Masters must hold arvalid and araddr stable until accepted, per AXI.
- R_x:
  - m_rready = granted master's rready.
  - Granted master's rvalid, rdata and rresp = memory's m_rvalid, m_rdata and m_rresp.
  - On m_rvalid & m_rready, go to IDLE.
- The non-granted master always sees arready=0 and rvalid=0. Its rdata and rresp are driven to 0.
- All routing in AR_x and R_x is combinational from the state; there are no data registers.
- Minimum transaction (request seen at cycle 0, m_arready=1, m_rvalid=1 the following cycle):
  - AR handshake at cycle 1.
  - R handshake at cycle 2.
  - IDLE again at cycle 3.
  - A new grant can therefore be issued every 3 cycles.
- A requester dropping arvalid while in AR_x is illegal. Behaviour is undefined, but the FSM must stay in AR_x, not hang elsewhere.
- m_rvalid while in IDLE or AR_x is ignored and never forwarded.
- Reset asserted mid-transaction: the next edge returns to IDLE and the in-flight beat is discarded. The memory slave shares rst.
- busy = (state != IDLE). grant_id = 1 in AR_LS and R_LS, 0 otherwise.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register, reset to 1 (LSU), so the IFU wins the first contention.
  - It updates to the granted id on each IDLE->AR_x transition.
  - On simultaneous requests in IDLE, the master that is not last_grant wins.
  - A single requester always wins regardless of last_grant.
- Not defined: fixed priority, LSU over IFU. No last_grant register exists.

Test Plan:
- Reset then only the IFU requests:
  - Stimulus: rst=1 for 2 cycles, then if_arvalid=1, if_araddr=0x80000000; memory arready=1, rdata=0x0000001300000093 one cycle after AR.
  - Required: m_araddr=0x80000000 in AR_IF; if_rvalid=1 with that rdata exactly one cycle later; IDLE 3 cycles after the request.
- Simultaneous requests, macro off:
  - Stimulus: if_araddr=0x80000004, ls_araddr=0x80001000, both valid.
  - Required: LSU is served first (grant_id=1, m_araddr=0x80001000); the IFU is served next; if_arready=0 throughout the LSU transaction.
- Simultaneous requests, macro on, both held valid for 4 transactions:
  - Required: grant order IFU, LSU, IFU, LSU.
- Backpressure:
  - Stimulus: m_arready=0 for 3 cycles, then 1; m_rvalid=1 while ls_rready=0 for 2 cycles.
  - Required: state holds in AR_LS and then R_LS; m_rready=0 while ls_rready=0; the handshake completes only when both sides are high.
- Reset mid-transaction:
  - Stimulus: rst=1 while in R_IF.
  - Required: IDLE next cycle; busy=0; if_rvalid=0; a later m_rvalid in IDLE is not forwarded.
- Spurious data:
  - Stimulus: m_rvalid=1 with rresp=2'b10 while in IDLE.
  - Required: if_rvalid=ls_rvalid=0; no state change.

Source files
------------

// File: rtl/axi_lite_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_rd_arbiter_if
// Purpose : AXI-lite read-channel bundle (AR + R) shared by the arbiter ports.
// Revision: 1.0 - initial release
// ============================================================================
interface axi_lite_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rready;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_rd_arbiter
// Purpose : Two-master (IFU=0, LSU=1) AXI-lite read arbiter, one outstanding
//           transaction. Define ARB_ROUND_ROBIN_EN for round-robin contention
//           resolution; otherwise LSU has fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
module axi_lite_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    axi_lite_rd_arbiter_if.slave        ifu,
    axi_lite_rd_arbiter_if.slave        lsu,
    axi_lite_rd_arbiter_if.master       mem,
    output logic                        busy,
    output logic                        grant_id
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_AR_IF = 3'd1;
    localparam logic [2:0] c_R_IF  = 3'd2;
    localparam logic [2:0] c_AR_LS = 3'd3;
    localparam logic [2:0] c_R_LS  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       w_pick_ls;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Under contention the master that did not win last time gets the port.
    always_comb begin
        if (ifu.arvalid && lsu.arvalid) begin
            w_pick_ls = ~r_last_grant;
        end else begin
            w_pick_ls = lsu.arvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if ((r_state == c_IDLE) && (ifu.arvalid || lsu.arvalid)) begin
            r_last_grant <= w_pick_ls;
        end
    end
`else
    assign w_pick_ls = lsu.arvalid;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (ifu.arvalid || lsu.arvalid) begin
                    w_state_nxt = w_pick_ls ? c_AR_LS : c_AR_IF;
                end
            end
            c_AR_IF: if (mem.arready) w_state_nxt = c_R_IF;
            c_R_IF:  if (mem.rvalid && ifu.rready) w_state_nxt = c_IDLE;
            c_AR_LS: if (mem.arready) w_state_nxt = c_R_LS;
            c_R_LS:  if (mem.rvalid && lsu.rready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pure state-driven routing; the non-granted side is parked at zero.
    always_comb begin
        mem.arvalid = 1'b0;
        mem.araddr  = {ADDR_W{1'b0}};
        mem.rready  = 1'b0;
        ifu.arready = 1'b0;
        ifu.rvalid  = 1'b0;
        ifu.rdata   = {DATA_W{1'b0}};
        ifu.rresp   = 2'b00;
        lsu.arready = 1'b0;
        lsu.rvalid  = 1'b0;
        lsu.rdata   = {DATA_W{1'b0}};
        lsu.rresp   = 2'b00;
        case (r_state)
            c_AR_IF: begin
                mem.arvalid = 1'b1;
                mem.araddr  = ifu.araddr;
                ifu.arready = mem.arready;
            end
            c_R_IF: begin
                mem.rready = ifu.rready;
                ifu.rvalid = mem.rvalid;
                ifu.rdata  = mem.rdata;
                ifu.rresp  = mem.rresp;
            end
            c_AR_LS: begin
                mem.arvalid = 1'b1;
                mem.araddr  = lsu.araddr;
                lsu.arready = mem.arready;
            end
            c_R_LS: begin
                mem.rready = lsu.rready;
                lsu.rvalid = mem.rvalid;
                lsu.rdata  = mem.rdata;
                lsu.rresp  = mem.rresp;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (r_state != c_IDLE);
    assign grant_id = (r_state == c_AR_LS) || (r_state == c_R_LS);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_rd_arbiter
// Purpose : Self-checking bench: directed scenarios plus random traffic checked
//           against a transaction-level arbitration model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_lite_rd_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic grant_id;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic model_last = 1'b1;

    axi_lite_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifu_bus ();
    axi_lite_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lsu_bus ();
    axi_lite_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    axi_lite_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ifu      (ifu_bus),
        .lsu      (lsu_bus),
        .mem      (mem_bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference arbitration rule: single requester wins; contention goes to
    // LSU, or to whoever was not granted last when round robin is enabled.
    function automatic logic model_pick(input logic ifr, input logic lsr);
        logic pick;
        if (ifr && lsr) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = ~model_last;
`else
            pick = 1'b1;
`endif
        end else begin
            pick = lsr;
        end
        return pick;
    endfunction

    // Entered and left at a falling edge with the arbiter idle.
    task automatic txn(input int ar_wait, input int r_wait, input int rr_wait,
                       input bit keep, input logic [63:0] data);
        logic        g;
        logic [31:0] addr;
        logic [1:0]  resp;
        int          n;
        g    = model_pick(ifu_bus.arvalid, lsu_bus.arvalid);
        model_last = g;
        addr = g ? lsu_bus.araddr : ifu_bus.araddr;
        resp = 2'($urandom_range(0, 3));
        n    = (r_wait > rr_wait) ? r_wait : rr_wait;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_m_arvalid", mem_bus.arvalid, 0);
        chk("idle_m_araddr", mem_bus.araddr, 0);
        chk("idle_arready", ifu_bus.arready | lsu_bus.arready, 0);
        @(negedge clk);
        for (int i = 0; i <= ar_wait; i++) begin
            mem_bus.arready = (i == ar_wait);
            mem_bus.rvalid  = 1'($urandom_range(0, 1));
            mem_bus.rdata   = {$urandom(), $urandom()};
            ifu_bus.rready  = 1'($urandom_range(0, 1));
            lsu_bus.rready  = 1'($urandom_range(0, 1));
            #1;
            chk("ar_busy", busy, 1);
            chk("ar_grant_id", grant_id, g);
            chk("ar_m_arvalid", mem_bus.arvalid, 1);
            chk("ar_m_araddr", mem_bus.araddr, addr);
            chk("ar_arready", g ? lsu_bus.arready : ifu_bus.arready, (i == ar_wait));
            chk("ar_other_arready", g ? ifu_bus.arready : lsu_bus.arready, 0);
            chk("ar_rvalid_blocked", ifu_bus.rvalid | lsu_bus.rvalid, 0);
            chk("ar_m_rready", mem_bus.rready, 0);
            @(negedge clk);
        end
        mem_bus.arready = 1'b0;
        if (!keep) begin
            if (g) lsu_bus.arvalid = 1'b0;
            else   ifu_bus.arvalid = 1'b0;
        end
        for (int j = 0; j <= n; j++) begin
            mem_bus.rvalid = (j >= r_wait);
            mem_bus.rdata  = (j >= r_wait) ? data : {$urandom(), $urandom()};
            mem_bus.rresp  = resp;
            if (g) begin
                lsu_bus.rready = (j >= rr_wait);
                ifu_bus.rready = 1'($urandom_range(0, 1));
            end else begin
                ifu_bus.rready = (j >= rr_wait);
                lsu_bus.rready = 1'($urandom_range(0, 1));
            end
            #1;
            chk("r_busy", busy, 1);
            chk("r_grant_id", grant_id, g);
            chk("r_m_arvalid", mem_bus.arvalid, 0);
            chk("r_m_rready", mem_bus.rready, (j >= rr_wait));
            chk("r_rvalid", g ? lsu_bus.rvalid : ifu_bus.rvalid, (j >= r_wait));
            chk("r_other_rvalid", g ? ifu_bus.rvalid : lsu_bus.rvalid, 0);
            chk("r_other_rdata", g ? ifu_bus.rdata : lsu_bus.rdata, 0);
            chk("r_other_rresp", g ? ifu_bus.rresp : lsu_bus.rresp, 0);
            if (j >= r_wait) begin
                chk("r_rdata", g ? lsu_bus.rdata : ifu_bus.rdata, data);
                chk("r_rresp", g ? lsu_bus.rresp : ifu_bus.rresp, resp);
            end
            @(negedge clk);
        end
        mem_bus.rvalid = 1'b0;
        ifu_bus.rready = 1'b0;
        lsu_bus.rready = 1'b0;
        #1;
        chk("done_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        ifu_bus.arvalid = 1'b0; ifu_bus.araddr = '0; ifu_bus.rready = 1'b0;
        lsu_bus.arvalid = 1'b0; lsu_bus.araddr = '0; lsu_bus.rready = 1'b0;
        mem_bus.arready = 1'b0; mem_bus.rvalid = 1'b0;
        mem_bus.rdata = '0; mem_bus.rresp = 2'b00;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_m_arvalid", mem_bus.arvalid, 0);
        chk("rst_m_rready", mem_bus.rready, 0);
        chk("rst_arready", ifu_bus.arready | lsu_bus.arready, 0);
        chk("rst_rvalid", ifu_bus.rvalid | lsu_bus.rvalid, 0);
        rst = 1'b0;
        model_last = 1'b1;

        // IFU alone, minimum latency
        ifu_bus.arvalid = 1'b1; ifu_bus.araddr = 32'h8000_0000;
        txn(0, 0, 0, 1'b0, 64'h0000_0013_0000_0093);

        // Simultaneous requests
        ifu_bus.arvalid = 1'b1; ifu_bus.araddr = 32'h8000_0004;
        lsu_bus.arvalid = 1'b1; lsu_bus.araddr = 32'h8000_1000;
        txn(0, 0, 0, 1'b0, {$urandom(), $urandom()});
        txn(0, 0, 0, 1'b0, {$urandom(), $urandom()});

        // Backpressure on both channels
        lsu_bus.arvalid = 1'b1; lsu_bus.araddr = 32'h8000_2000;
        txn(3, 0, 2, 1'b0, {$urandom(), $urandom()});

        // Reset while in R_IF
        ifu_bus.arvalid = 1'b1; ifu_bus.araddr = 32'h8000_3000;
        @(negedge clk);
        mem_bus.arready = 1'b1;
        @(negedge clk);
        ifu_bus.arvalid = 1'b0; mem_bus.arready = 1'b0;
        #1;
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_grant", grant_id, 0);
        rst = 1'b1; mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'h1234; ifu_bus.rready = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_if_rvalid", ifu_bus.rvalid, 0);
        rst = 1'b0; model_last = 1'b1; ifu_bus.rready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("mid_after_busy", busy, 0);
            chk("mid_after_rvalid", ifu_bus.rvalid | lsu_bus.rvalid, 0);
            chk("mid_after_m_rready", mem_bus.rready, 0);
        end

        // Spurious read data while idle
        mem_bus.rvalid = 1'b1; mem_bus.rresp = 2'b10; mem_bus.rdata = 64'hdead_beef;
        lsu_bus.rready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("spur_busy", busy, 0);
            chk("spur_rvalid", ifu_bus.rvalid | lsu_bus.rvalid, 0);
            chk("spur_rresp", {ifu_bus.rresp, lsu_bus.rresp}, 0);
        end
        mem_bus.rvalid = 1'b0; mem_bus.rresp = 2'b00;
        ifu_bus.rready = 1'b0; lsu_bus.rready = 1'b0;

        // Sustained contention, both held valid for four transactions
        ifu_bus.arvalid = 1'b1; ifu_bus.araddr = 32'h8000_4000;
        lsu_bus.arvalid = 1'b1; lsu_bus.araddr = 32'h8000_5000;
        repeat (4) txn(0, 1, 0, 1'b1, {$urandom(), $urandom()});
        ifu_bus.arvalid = 1'b0; lsu_bus.arvalid = 1'b0;
        @(negedge clk);

        // Random traffic; a losing requester keeps its request stable
        for (int k = 0; k < 24; k++) begin
            if (!ifu_bus.arvalid && ($urandom_range(0, 1) == 1)) begin
                ifu_bus.arvalid = 1'b1; ifu_bus.araddr = $urandom();
            end
            if (!lsu_bus.arvalid && ($urandom_range(0, 1) == 1)) begin
                lsu_bus.arvalid = 1'b1; lsu_bus.araddr = $urandom();
            end
            if (!ifu_bus.arvalid && !lsu_bus.arvalid) begin
                ifu_bus.arvalid = 1'b1; ifu_bus.araddr = $urandom();
            end
            txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                1'b0, {$urandom(), $urandom()});
        end
        ifu_bus.arvalid = 1'b0; lsu_bus.arvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
